// File: rtl/phys_tag_free_list_pkg.sv
// Shared types and sizing for the physical-register free list, plus helpers
// for slot arithmetic and free-request classification.
package phys_tag_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int TAG_W     = $clog2(NUM_PREGS);
    localparam int NUM_ARCH  = 32;
    localparam int DEPTH     = NUM_PREGS - NUM_ARCH;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [CNT_W-1:0]     cnt_t;
    typedef logic [NUM_PREGS-1:0] bitmap_t;

    typedef enum logic [1:0] {
        FREE_ACCEPT   = 2'd0,
        FREE_IGNORE   = 2'd1,
        FREE_DOUBLE   = 2'd2,
        FREE_OVERFLOW = 2'd3
    } free_verdict_e;

    localparam cnt_t    DEPTH_CNT  = cnt_t'(DEPTH);
    localparam cnt_t    CNT_ZERO   = {CNT_W{1'b0}};
    localparam tag_t    TAG_ZERO   = {TAG_W{1'b0}};
    localparam bitmap_t BITMAP_RST = {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};

    function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
        cnt_t sum;
        sum = cnt_t'(p) + cnt_t'(n);
        if (sum >= DEPTH_CNT) begin
            sum = sum - DEPTH_CNT;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    function automatic bitmap_t tag_onehot(input tag_t tag);
        return bitmap_t'(1'b1) << tag;
    endfunction

    // Tag 0 (x0) is never tracked; a double free outranks an overflow.
    function automatic free_verdict_e classify_free(input logic valid, input tag_t tag,
                                                    input logic already_free,
                                                    input logic has_room);
        free_verdict_e v;
        if (!valid || (tag == TAG_ZERO)) begin
            v = FREE_IGNORE;
        end else if (already_free) begin
            v = FREE_DOUBLE;
        end else if (!has_room) begin
            v = FREE_OVERFLOW;
        end else begin
            v = FREE_ACCEPT;
        end
        return v;
    endfunction

endpackage

// File: rtl/phys_tag_free_list_fifo.sv
// Circular tag buffer with two compacting write ports, one read port and an
// occupancy count. Reset preloads it with the non-architectural tags.
module tag_fifo_2w1r
    import phys_tag_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pop_i,
    input  logic             wr0_en_i,
    input  logic [TAG_W-1:0] wr0_tag_i,
    input  logic             wr1_en_i,
    input  logic [TAG_W-1:0] wr1_tag_i,
    output logic [TAG_W-1:0] head_tag_o,
    output logic [CNT_W-1:0] count_o
);

    tag_t mem_q [DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic       pop_ok_s;
    logic [1:0] n_push_s;
    ptr_t       wr1_slot_s;

    // Pointer and count next-state; port 1 lands right behind port 0 only if port 0 wrote.
    always_comb begin
        pop_ok_s   = pop_i && (count_q != CNT_ZERO);
        n_push_s   = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};
        wr1_slot_s = wr0_en_i ? ptr_add(tail_q, 2'd1) : tail_q;
        head_d     = pop_ok_s ? ptr_add(head_q, 2'd1) : head_q;
        tail_d     = ptr_add(tail_q, n_push_s);
        count_d    = count_q - cnt_t'(pop_ok_s) + cnt_t'(n_push_s);
    end

    // Storage, pointers and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= tag_t'(NUM_ARCH + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_CNT;
        end else begin
            if (wr0_en_i) begin
                mem_q[tail_q] <= wr0_tag_i;
            end
            if (wr1_en_i) begin
                mem_q[wr1_slot_s] <= wr1_tag_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_tag_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/phys_tag_free_list.sv
// Physical-register free list: hands out tags to rename and takes back retired
// tags from the ROB, screening each free against a per-tag is-free bitmap.
module phys_tag_free_list
    import phys_tag_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_1_valid,
    input  logic [TAG_W-1:0] free_1_tag,
    input  logic             free_2_valid,
    input  logic [TAG_W-1:0] free_2_tag,
    output logic [CNT_W-1:0] free_count,
    output logic             err_double_free,
    output logic             err_overflow
);

    tag_t          head_tag_s;
    cnt_t          count_s;
    logic          pop_s;
    cnt_t          cap_s;
    bitmap_t       bm_pop_s, bm_mid_s;
    bitmap_t       bitmap_q, bitmap_d;
    free_verdict_e v1_s, v2_s;
    logic          acc1_s, acc2_s;
    logic          err_double_q, err_double_d;
    logic          err_overflow_q, err_overflow_d;

    tag_fifo_2w1r u_fifo (
        .clk        (clk),
        .reset      (reset),
        .pop_i      (pop_s),
        .wr0_en_i   (acc1_s),
        .wr0_tag_i  (free_1_tag),
        .wr1_en_i   (acc2_s),
        .wr1_tag_i  (free_2_tag),
        .head_tag_o (head_tag_s),
        .count_o    (count_s)
    );

    // Resolve pop, then free_1, then free_2 against a progressively updated bitmap.
    always_comb begin
        pop_s    = alloc_req && (count_s != CNT_ZERO);
        cap_s    = DEPTH_CNT - count_s + cnt_t'(pop_s);
        bm_pop_s = bitmap_q;
        if (pop_s) begin
            bm_pop_s[head_tag_s] = 1'b0;
        end else begin
            bm_pop_s = bitmap_q;
        end

        v1_s     = classify_free(free_1_valid, free_1_tag, bm_pop_s[free_1_tag],
                                 cap_s != CNT_ZERO);
        acc1_s   = (v1_s == FREE_ACCEPT);
        bm_mid_s = acc1_s ? (bm_pop_s | tag_onehot(free_1_tag)) : bm_pop_s;

        v2_s     = classify_free(free_2_valid, free_2_tag, bm_mid_s[free_2_tag],
                                 cap_s > cnt_t'(acc1_s));
        acc2_s   = (v2_s == FREE_ACCEPT);
        bitmap_d = acc2_s ? (bm_mid_s | tag_onehot(free_2_tag)) : bm_mid_s;

        err_double_d   = err_double_q   || (v1_s == FREE_DOUBLE)   || (v2_s == FREE_DOUBLE);
        err_overflow_d = err_overflow_q || (v1_s == FREE_OVERFLOW) || (v2_s == FREE_OVERFLOW);
    end

    // Bitmap and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_q       <= BITMAP_RST;
            err_double_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            bitmap_q       <= bitmap_d;
            err_double_q   <= err_double_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign alloc_valid     = (count_s != CNT_ZERO);
    assign alloc_tag       = head_tag_s;
    assign free_count      = count_s;
    assign err_double_free = err_double_q;
    assign err_overflow    = err_overflow_q;

endmodule

// File: tb/tb_phys_tag_free_list.sv
// Scenario bench for phys_tag_free_list: a queue holds the expected order of
// free tags, pushed when frees are driven and popped when rename allocates.
module tb_phys_tag_free_list;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       free_1_valid;
    logic [5:0] free_1_tag;
    logic       free_2_valid;
    logic [5:0] free_2_tag;
    logic [5:0] free_count;
    logic       err_double_free;
    logic       err_overflow;

    int         tests_run;
    int         tests_failed;
    logic [5:0] exp_q [$];
    logic [5:0] exp_tag;

    phys_tag_free_list dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .free_1_valid    (free_1_valid),
        .free_1_tag      (free_1_tag),
        .free_2_valid    (free_2_valid),
        .free_2_tag      (free_2_tag),
        .free_count      (free_count),
        .err_double_free (err_double_free),
        .err_overflow    (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic areq, input logic v1, input logic [5:0] t1,
                          input logic v2, input logic [5:0] t2);
        alloc_req    = areq;
        free_1_valid = v1;
        free_1_tag   = t1;
        free_2_valid = v2;
        free_2_tag   = t2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
    endtask

    // Pop n tags, comparing each one against the head of the scoreboard.
    task automatic pop_and_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL %s: scoreboard empty at pop %0d", name, i);
            end else begin
                exp_tag = exp_q.pop_front();
                if (alloc_valid !== 1'b1 || alloc_tag !== exp_tag) begin
                    tests_failed++;
                    $display("FAIL %s[%0d]: got valid=%0b tag=%0d, expected valid=1 tag=%0d",
                             name, i, alloc_valid, alloc_tag, exp_tag);
                end
            end
            set_in(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (alloc_valid !== 1'b1 || alloc_tag !== 6'd32 || free_count !== 6'd32 ||
            err_double_free !== 1'b0 || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: got v=%0b tag=%0d cnt=%0d dbl=%0b ovf=%0b, expected 1 32 32 0 0",
                     alloc_valid, alloc_tag, free_count, err_double_free, err_overflow);
        end
    endtask

    task automatic test_drain();
        pop_and_check(32, "drain");
        tests_run++;
        if (alloc_valid !== 1'b0 || free_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: got v=%0b cnt=%0d, expected 0 0", alloc_valid, free_count);
        end
        set_in(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        tick();
        tests_run++;
        if (alloc_valid !== 1'b0 || free_count !== 6'd0 || err_double_free !== 1'b0 ||
            err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL alloc_empty: got v=%0b cnt=%0d dbl=%0b ovf=%0b, expected 0 0 0 0",
                     alloc_valid, free_count, err_double_free, err_overflow);
        end
    endtask

    // Runs from the empty state left by test_drain.
    task automatic test_free_from_empty();
        set_in(1'b0, 1'b1, 6'd40, 1'b1, 6'd35);
        #1;
        tests_run++;
        if (alloc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_bypass: got alloc_valid=%0b, expected 0", alloc_valid);
        end
        exp_q.push_back(6'd40);
        exp_q.push_back(6'd35);
        tick();
        tests_run++;
        if (free_count !== 6'd2) begin
            tests_failed++;
            $display("FAIL two_free_count: got %0d, expected 2", free_count);
        end
        pop_and_check(1, "free_empty_a");
        set_in(1'b0, 1'b0, 6'd0, 1'b1, 6'd7);
        exp_q.push_back(6'd7);
        tick();
        tests_run++;
        if (free_count !== 6'd2) begin
            tests_failed++;
            $display("FAIL lone_free2_count: got %0d, expected 2", free_count);
        end
        pop_and_check(2, "free_empty_b");
        tests_run++;
        if (err_double_free !== 1'b0 || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL free_empty_err: got dbl=%0b ovf=%0b, expected 0 0",
                     err_double_free, err_overflow);
        end
    endtask

    task automatic test_wrap_pop_free();
        do_reset();
        set_in(1'b1, 1'b1, 6'd32, 1'b0, 6'd0);
        exp_tag = exp_q.pop_front();
        tests_run++;
        if (alloc_tag !== exp_tag) begin
            tests_failed++;
            $display("FAIL wrap_head: got %0d, expected %0d", alloc_tag, exp_tag);
        end
        exp_q.push_back(6'd32);
        tick();
        tests_run++;
        if (free_count !== 6'd32 || err_double_free !== 1'b0 || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_state: got cnt=%0d dbl=%0b ovf=%0b, expected 32 0 0",
                     free_count, err_double_free, err_overflow);
        end
        pop_and_check(32, "wrap_order");
    endtask

    task automatic test_double_free();
        do_reset();
        set_in(1'b0, 1'b1, 6'd50, 1'b0, 6'd0);
        tick();
        tests_run++;
        if (err_double_free !== 1'b1 || free_count !== 6'd32 || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL double_free: got dbl=%0b cnt=%0d ovf=%0b, expected 1 32 0",
                     err_double_free, free_count, err_overflow);
        end
    endtask

    task automatic test_zero_and_same_tag();
        do_reset();
        set_in(1'b0, 1'b1, 6'd0, 1'b0, 6'd0);
        tick();
        tests_run++;
        if (err_double_free !== 1'b0 || err_overflow !== 1'b0 || free_count !== 6'd32) begin
            tests_failed++;
            $display("FAIL tag_zero: got dbl=%0b ovf=%0b cnt=%0d, expected 0 0 32",
                     err_double_free, err_overflow, free_count);
        end
        pop_and_check(14, "pop_to_45");
        set_in(1'b0, 1'b1, 6'd45, 1'b1, 6'd45);
        exp_q.push_back(6'd45);
        tick();
        tests_run++;
        if (free_count !== 6'd19 || err_double_free !== 1'b1 || err_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_tag: got cnt=%0d dbl=%0b ovf=%0b, expected 19 1 0",
                     free_count, err_double_free, err_overflow);
        end
        pop_and_check(19, "same_tag_order");
    endtask

    task automatic test_overflow();
        do_reset();
        pop_and_check(1, "ovf_pop");
        set_in(1'b0, 1'b1, 6'd10, 1'b1, 6'd11);
        exp_q.push_back(6'd10);
        tick();
        tests_run++;
        if (free_count !== 6'd32 || err_overflow !== 1'b1 || err_double_free !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow: got cnt=%0d ovf=%0b dbl=%0b, expected 32 1 0",
                     free_count, err_overflow, err_double_free);
        end
        pop_and_check(32, "ovf_order");
        // Reset must also swallow the alloc and free presented alongside it.
        reset = 1'b1;
        set_in(1'b1, 1'b1, 6'd5, 1'b1, 6'd6);
        tick();
        reset = 1'b0;
        tests_run++;
        if (err_overflow !== 1'b0 || err_double_free !== 1'b0 || free_count !== 6'd32 ||
            alloc_tag !== 6'd32) begin
            tests_failed++;
            $display("FAIL reset_clear: got ovf=%0b dbl=%0b cnt=%0d tag=%0d, expected 0 0 32 32",
                     err_overflow, err_double_free, free_count, alloc_tag);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        set_in(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        #2;
        test_reset();
        test_drain();
        test_free_from_empty();
        test_wrap_pop_free();
        test_double_free();
        test_zero_and_same_tag();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
